// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship ship-memory blocks.
// Word layout: [2:0] ship type, slot k at [10+8k -: 8], [63:43] reserved.
// Slot layout: [7] ativo, [6] reserved, [5:3] linha, [2:0] coluna.
package batalha_pkg;

  localparam int unsigned NUM_ENTRADAS = 11;
  localparam int unsigned LARGURA      = 64;
  localparam int unsigned NUM_SLOTS    = 5;
  localparam int unsigned TAM_SLOT     = 8;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned COORD_W      = 3;
  localparam int unsigned NUM_W        = 3;
  localparam int unsigned CONT_W       = 5;
  localparam int unsigned CONT_MAX     = 31;

  localparam int unsigned SLOT_BASE    = 3;
  localparam int unsigned ATIVO_BIT    = 7;
  localparam int unsigned LINHA_MSB    = 5;
  localparam int unsigned LINHA_LSB    = 3;
  localparam int unsigned COLUNA_MSB   = 2;
  localparam int unsigned COLUNA_LSB   = 0;
  localparam int unsigned TIPO_MSB     = 2;
  localparam int unsigned TIPO_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VARRE = 2'd1,
    FIM   = 2'd2
  } estado_t;

  // Bit position of the LSB of slot k inside a memory word.
  function automatic int unsigned slot_lsb(input int unsigned k);
    return SLOT_BASE + k * TAM_SLOT;
  endfunction

endpackage

// File: rtl/limpa_slots.sv
// Combinational slot clearer: zeroes every active slot of a word that matches
// the shot coordinate and reports hit, sunk and number of cleared slots.
// Ports: i_palavra (word in), i_linha/i_coluna (shot), o_palavra (cleaned word),
//        o_acerto (any slot cleared), o_afundou (word went from >=1 to 0 active),
//        o_num_limpos (slots cleared, 0..5).
module limpa_slots
  import batalha_pkg::*;
(
  input  logic [LARGURA-1:0] i_palavra,
  input  logic [COORD_W-1:0] i_linha,
  input  logic [COORD_W-1:0] i_coluna,
  output logic [LARGURA-1:0] o_palavra,
  output logic               o_acerto,
  output logic               o_afundou,
  output logic [NUM_W-1:0]   o_num_limpos
);

  logic [NUM_W-1:0] w_num_ativos;
  logic [NUM_W-1:0] w_num_limpos;

  // Empty slots are excluded by ativo, so (0,0) is a legal shot.
  always_comb begin
    o_palavra    = i_palavra;
    w_num_ativos = '0;
    w_num_limpos = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (i_palavra[slot_lsb(k) + ATIVO_BIT]) begin
        w_num_ativos = w_num_ativos + NUM_W'(1);
        if (i_palavra[slot_lsb(k) + LINHA_LSB +: COORD_W] == i_linha &&
            i_palavra[slot_lsb(k) + COLUNA_LSB +: COORD_W] == i_coluna) begin
          o_palavra[slot_lsb(k) +: TAM_SLOT] = '0;
          w_num_limpos = w_num_limpos + NUM_W'(1);
        end
      end
    end
  end

  assign o_num_limpos = w_num_limpos;
  assign o_acerto     = (w_num_limpos != '0);
  assign o_afundou    = (w_num_ativos != '0) && (w_num_ativos == w_num_limpos);

endmodule

// File: rtl/registro_disparo.sv
// Applies one shot to the selected player's ship memory: scans the 11 entries
// one per clock, writes back words with matching slots cleared, and reports
// hit / sunk / sunk ship type.
// Ports: clk, rst_n (async active-low); start/jogador/linha/coluna (shot request);
//        addr, memoriaP1/P2 (read data), we_P1/we_P2, wr_data (write port);
//        busy, ready, acerto, afundou, tipo_afundado (status).
// Optional: define CONTADOR_ACERTOS_EN to add saturating per-player hit counters
//           acertos_P1 / acertos_P2.
module registro_disparo
  import batalha_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               jogador,
  input  logic [COORD_W-1:0] linha,
  input  logic [COORD_W-1:0] coluna,
  output logic [ADDR_W-1:0]  addr,
  input  logic [LARGURA-1:0] memoriaP1,
  input  logic [LARGURA-1:0] memoriaP2,
  output logic               we_P1,
  output logic               we_P2,
  output logic [LARGURA-1:0] wr_data,
  output logic               busy,
  output logic               ready,
  output logic               acerto,
  output logic               afundou,
  output logic [2:0]         tipo_afundado
`ifdef CONTADOR_ACERTOS_EN
  ,
  output logic [CONT_W-1:0]  acertos_P1,
  output logic [CONT_W-1:0]  acertos_P2
`endif
);

  estado_t             r_estado, w_estado_prox;
  logic [ADDR_W-1:0]   r_addr, w_addr_prox;
  logic                r_jogador, w_jogador_prox;
  logic [COORD_W-1:0]  r_linha, w_linha_prox;
  logic [COORD_W-1:0]  r_coluna, w_coluna_prox;
  logic                r_acerto, w_acerto_prox;
  logic                r_afundou, w_afundou_prox;
  logic [2:0]          r_tipo, w_tipo_prox;

  logic [LARGURA-1:0]  w_palavra;
  logic [LARGURA-1:0]  w_limpa;
  logic                w_match;
  logic                w_sunk;
  logic [NUM_W-1:0]    w_num;

  assign w_palavra = r_jogador ? memoriaP2 : memoriaP1;

  limpa_slots u_limpa (
    .i_palavra    (w_palavra),
    .i_linha      (r_linha),
    .i_coluna     (r_coluna),
    .o_palavra    (w_limpa),
    .o_acerto     (w_match),
    .o_afundou    (w_sunk),
    .o_num_limpos (w_num)
  );

`ifdef CONTADOR_ACERTOS_EN
  logic [CONT_W-1:0] r_acertos_P1, w_acertos_P1_prox;
  logic [CONT_W-1:0] r_acertos_P2, w_acertos_P2_prox;
  logic [CONT_W:0]   w_soma_P1;
  logic [CONT_W:0]   w_soma_P2;

  assign w_soma_P1 = (CONT_W+1)'(r_acertos_P1) + (CONT_W+1)'(w_num);
  assign w_soma_P2 = (CONT_W+1)'(r_acertos_P2) + (CONT_W+1)'(w_num);
`endif

  // Next-state, datapath next values and write-port strobes.
  always_comb begin
    w_estado_prox  = r_estado;
    w_addr_prox    = r_addr;
    w_jogador_prox = r_jogador;
    w_linha_prox   = r_linha;
    w_coluna_prox  = r_coluna;
    w_acerto_prox  = r_acerto;
    w_afundou_prox = r_afundou;
    w_tipo_prox    = r_tipo;
    we_P1          = 1'b0;
    we_P2          = 1'b0;
    wr_data        = '0;
`ifdef CONTADOR_ACERTOS_EN
    w_acertos_P1_prox = r_acertos_P1;
    w_acertos_P2_prox = r_acertos_P2;
`endif
    unique case (r_estado)
      IDLE: begin
        w_addr_prox = '0;
        if (start) begin
          w_jogador_prox = jogador;
          w_linha_prox   = linha;
          w_coluna_prox  = coluna;
          w_acerto_prox  = 1'b0;
          w_afundou_prox = 1'b0;
          w_tipo_prox    = '0;
          w_estado_prox  = VARRE;
        end
      end
      VARRE: begin
        wr_data = w_limpa;
        if (w_match) begin
          we_P1         = ~r_jogador;
          we_P2         = r_jogador;
          w_acerto_prox = 1'b1;
`ifdef CONTADOR_ACERTOS_EN
          if (r_jogador)
            w_acertos_P2_prox = (w_soma_P2 > (CONT_W+1)'(CONT_MAX)) ? CONT_W'(CONT_MAX)
                                                                     : w_soma_P2[CONT_W-1:0];
          else
            w_acertos_P1_prox = (w_soma_P1 > (CONT_W+1)'(CONT_MAX)) ? CONT_W'(CONT_MAX)
                                                                     : w_soma_P1[CONT_W-1:0];
`endif
        end
        // Only the lowest-addressed sunk ship records its type.
        if (w_sunk && !r_afundou) begin
          w_afundou_prox = 1'b1;
          w_tipo_prox    = w_palavra[TIPO_MSB:TIPO_LSB];
        end
        if (r_addr == ADDR_W'(NUM_ENTRADAS - 1)) begin
          w_addr_prox   = '0;
          w_estado_prox = FIM;
        end else begin
          w_addr_prox = r_addr + ADDR_W'(1);
        end
      end
      FIM: begin
        w_estado_prox = IDLE;
      end
      default: begin
        w_estado_prox = IDLE;
        w_addr_prox   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= IDLE;
      r_addr    <= '0;
      r_jogador <= 1'b0;
      r_linha   <= '0;
      r_coluna  <= '0;
      r_acerto  <= 1'b0;
      r_afundou <= 1'b0;
      r_tipo    <= '0;
`ifdef CONTADOR_ACERTOS_EN
      r_acertos_P1 <= '0;
      r_acertos_P2 <= '0;
`endif
    end else begin
      r_estado  <= w_estado_prox;
      r_addr    <= w_addr_prox;
      r_jogador <= w_jogador_prox;
      r_linha   <= w_linha_prox;
      r_coluna  <= w_coluna_prox;
      r_acerto  <= w_acerto_prox;
      r_afundou <= w_afundou_prox;
      r_tipo    <= w_tipo_prox;
`ifdef CONTADOR_ACERTOS_EN
      r_acertos_P1 <= w_acertos_P1_prox;
      r_acertos_P2 <= w_acertos_P2_prox;
`endif
    end
  end

  assign addr          = r_addr;
  assign busy          = (r_estado != IDLE);
  assign ready         = (r_estado == FIM);
  assign acerto        = r_acerto;
  assign afundou       = r_afundou;
  assign tipo_afundado = r_tipo;
`ifdef CONTADOR_ACERTOS_EN
  assign acertos_P1    = r_acertos_P1;
  assign acertos_P2    = r_acertos_P2;
`endif

endmodule

// File: tb/tb_registro_disparo.sv
// Self-checking bench for registro_disparo with a two-player memory model.
module tb_registro_disparo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        jogador;
  logic [2:0]  linha;
  logic [2:0]  coluna;
  logic [4:0]  addr;
  logic [63:0] memoriaP1;
  logic [63:0] memoriaP2;
  logic        we_P1;
  logic        we_P2;
  logic [63:0] wr_data;
  logic        busy;
  logic        ready;
  logic        acerto;
  logic        afundou;
  logic [2:0]  tipo_afundado;
`ifdef CONTADOR_ACERTOS_EN
  logic [4:0]  acertos_P1;
  logic [4:0]  acertos_P2;
`endif

  int checks = 0;
  int errors = 0;

  registro_disparo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .jogador       (jogador),
    .linha         (linha),
    .coluna        (coluna),
    .addr          (addr),
    .memoriaP1     (memoriaP1),
    .memoriaP2     (memoriaP2),
    .we_P1         (we_P1),
    .we_P2         (we_P2),
    .wr_data       (wr_data),
    .busy          (busy),
    .ready         (ready),
    .acerto        (acerto),
    .afundou       (afundou),
    .tipo_afundado (tipo_afundado)
`ifdef CONTADOR_ACERTOS_EN
    ,
    .acertos_P1    (acertos_P1),
    .acertos_P2    (acertos_P2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge; bench loads share the port.
  logic [63:0] mem_p1 [0:31];
  logic [63:0] mem_p2 [0:31];
  logic        ld_en, ld_clr, ld_sel;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;

  assign memoriaP1 = mem_p1[addr];
  assign memoriaP2 = mem_p2[addr];

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 32; i++) begin
        mem_p1[i] <= '0;
        mem_p2[i] <= '0;
      end
    end else if (ld_en) begin
      if (ld_sel) mem_p2[ld_addr] <= ld_data;
      else        mem_p1[ld_addr] <= ld_data;
    end else begin
      if (we_P1) mem_p1[addr] <= wr_data;
      if (we_P2) mem_p2[addr] <= wr_data;
    end
  end

  // Write-strobe monitor.
  int n_we1 = 0;
  int n_we2 = 0;
  logic [4:0]  ult_addr;
  logic [63:0] ult_dados;
  always @(negedge clk) begin
    if (we_P1) begin n_we1++; ult_addr = addr; ult_dados = wr_data; end
    if (we_P2) begin n_we2++; ult_addr = addr; ult_dados = wr_data; end
  end

  task automatic mem_clear();
    @(negedge clk); ld_clr = 1'b1;
    @(negedge clk); ld_clr = 1'b0;
  endtask

  task automatic mem_load(input logic sel, input logic [4:0] a, input logic [63:0] d);
    @(negedge clk); ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  // Issues one shot and watches 20 cycles; k is the cycle index after acceptance.
  // Optional start pulses (cycles p1, p2) carry a different shot that must be ignored.
  task automatic run_shot(input logic j, input logic [2:0] l, input logic [2:0] c,
                          input int p1, input int p2,
                          output int t_rdy, output int n_rdy,
                          output int d_we1, output int d_we2,
                          output logic [4:0] addr_k1, output logic busy_k1);
    int b1, b2;
    @(negedge clk);
    b1 = n_we1; b2 = n_we2;
    jogador = j; linha = l; coluna = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_rdy = -1; n_rdy = 0;
    addr_k1 = addr; busy_k1 = busy;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (ready) begin
        n_rdy++;
        if (t_rdy < 0) t_rdy = k;
      end
      if (k == p1 || k == p2) begin
        start = 1'b1; jogador = 1'b0; linha = 3'd3; coluna = 3'd3;
      end else begin
        start = 1'b0;
      end
    end
    d_we1 = n_we1 - b1;
    d_we2 = n_we2 - b2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; jogador = 1'b0; linha = '0; coluna = '0;
    ld_en = 1'b0; ld_clr = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    mem_clear();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (addr !== 5'd0)   begin errors++; $display("FAIL reset_addr got %0d exp 0", addr); end
    checks++; if ({we_P1, we_P2} !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", {we_P1, we_P2}); end
    checks++; if (wr_data !== 64'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    checks++; if ({acerto, afundou, tipo_afundado} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {acerto, afundou, tipo_afundado}); end
`ifdef CONTADOR_ACERTOS_EN
    checks++; if ({acertos_P1, acertos_P2} !== 10'd0) begin
      errors++; $display("FAIL reset_contadores got %h exp 0", {acertos_P1, acertos_P2}); end
`endif
    rst_n = 1'b1;
  endtask

  // Single-slot ship sunk at addr 0; decoys: other coordinate, inactive slot with same coordinate.
  task automatic test_afunda();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    mem_load(1'b0, 5'd0, 64'h4D1);  // slot0 = 9A (3,2) active, type 1
    mem_load(1'b0, 5'd5, 64'h4DA);  // slot0 = 9B (3,3) active, type 2
    mem_load(1'b0, 5'd6, 64'h0D3);  // slot0 = 1A (3,2) inactive, type 3
    run_shot(1'b0, 3'd3, 3'd2, 0, 0, t, n, w1, w2, a1, bz);
    checks++; if (a1 !== 5'd0 || bz !== 1'b1) begin errors++; $display("FAIL afunda_ciclo1 got addr %0d busy %b exp 0 1", a1, bz); end
    checks++; if (t !== 12) begin errors++; $display("FAIL afunda_latencia got %0d exp 12", t); end
    checks++; if (n !== 1)  begin errors++; $display("FAIL afunda_num_ready got %0d exp 1", n); end
    checks++; if (w1 !== 1 || w2 !== 0) begin errors++; $display("FAIL afunda_escritas got %0d/%0d exp 1/0", w1, w2); end
    checks++; if (ult_addr !== 5'd0 || ult_dados !== 64'h1) begin
      errors++; $display("FAIL afunda_wr got addr %0d data %h exp 0 1", ult_addr, ult_dados); end
    checks++; if ({acerto, afundou, tipo_afundado} !== {1'b1, 1'b1, 3'd1}) begin
      errors++; $display("FAIL afunda_flags got %b exp 11001", {acerto, afundou, tipo_afundado}); end
    checks++; if (mem_p1[6] !== 64'h0D3 || mem_p1[5] !== 64'h4DA) begin
      errors++; $display("FAIL afunda_decoys got %h %h exp 4da d3", mem_p1[5], mem_p1[6]); end
  endtask

  localparam logic [63:0] P2_9_ANTES = 64'd4 | (64'h89 << 3) | (64'h8A << 11) | (64'h8B << 19) | (64'h8C << 27);
  localparam logic [63:0] P2_9_DEPOIS = 64'd4 | (64'h89 << 3) | (64'h8B << 19) | (64'h8C << 27);

  task automatic test_parcial();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    mem_load(1'b1, 5'd9, P2_9_ANTES);
    run_shot(1'b1, 3'd1, 3'd2, 0, 0, t, n, w1, w2, a1, bz);
    checks++; if (w1 !== 0 || w2 !== 1) begin errors++; $display("FAIL parcial_escritas got %0d/%0d exp 0/1", w1, w2); end
    checks++; if (ult_addr !== 5'd9 || ult_dados !== P2_9_DEPOIS) begin
      errors++; $display("FAIL parcial_wr got addr %0d data %h exp 9 %h", ult_addr, ult_dados, P2_9_DEPOIS); end
    checks++; if ({acerto, afundou, tipo_afundado} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL parcial_flags got %b exp 10000", {acerto, afundou, tipo_afundado}); end
    checks++; if (t !== 12) begin errors++; $display("FAIL parcial_latencia got %0d exp 12", t); end
  endtask

  task automatic test_repete();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    run_shot(1'b1, 3'd1, 3'd2, 0, 0, t, n, w1, w2, a1, bz);
    checks++; if (w1 !== 0 || w2 !== 0) begin errors++; $display("FAIL repete_escritas got %0d/%0d exp 0/0", w1, w2); end
    checks++; if ({acerto, afundou} !== 2'b00) begin errors++; $display("FAIL repete_flags got %b exp 00", {acerto, afundou}); end
    checks++; if (t !== 12 || n !== 1) begin errors++; $display("FAIL repete_ready got t %0d n %0d exp 12 1", t, n); end
    checks++; if (mem_p2[9] !== P2_9_DEPOIS) begin errors++; $display("FAIL repete_mem got %h exp %h", mem_p2[9], P2_9_DEPOIS); end
  endtask

  // Shot (0,0) matching several slots across two entries; reserved upper bits must survive.
  task automatic test_multiplo();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    mem_load(1'b1, 5'd2, 64'd6 | (64'h80 << 3) | (64'h80 << 27));
    mem_load(1'b1, 5'd7, (64'hABC << 48) | 64'd3 | (64'h92 << 3) | (64'h80 << 35));
    run_shot(1'b1, 3'd0, 3'd0, 0, 0, t, n, w1, w2, a1, bz);
    checks++; if (w1 !== 0 || w2 !== 2) begin errors++; $display("FAIL multiplo_escritas got %0d/%0d exp 0/2", w1, w2); end
    checks++; if ({acerto, afundou, tipo_afundado} !== {1'b1, 1'b1, 3'd6}) begin
      errors++; $display("FAIL multiplo_flags got %b exp 11110", {acerto, afundou, tipo_afundado}); end
    checks++; if (mem_p2[2] !== 64'd6) begin errors++; $display("FAIL multiplo_mem2 got %h exp 6", mem_p2[2]); end
    checks++; if (mem_p2[7] !== ((64'hABC << 48) | 64'd3 | (64'h92 << 3))) begin
      errors++; $display("FAIL multiplo_mem7 got %h", mem_p2[7]); end
    checks++; if (mem_p2[9] !== P2_9_DEPOIS) begin errors++; $display("FAIL multiplo_mem9 got %h exp %h", mem_p2[9], P2_9_DEPOIS); end
  endtask

  // Start pulses at N+3 and N+11 carry shot (3,3), which would sink P1 entry 5 if accepted.
  task automatic test_start_ignorado();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    run_shot(1'b0, 3'd7, 3'd7, 3, 11, t, n, w1, w2, a1, bz);
    checks++; if (n !== 1 || t !== 12) begin errors++; $display("FAIL ignora_ready got n %0d t %0d exp 1 12", n, t); end
    checks++; if (w1 !== 0 || w2 !== 0) begin errors++; $display("FAIL ignora_escritas got %0d/%0d exp 0/0", w1, w2); end
    checks++; if ({acerto, afundou, tipo_afundado} !== 5'b0) begin
      errors++; $display("FAIL ignora_flags got %b exp 00000", {acerto, afundou, tipo_afundado}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignora_idle got busy %b exp 0", busy); end
    run_shot(1'b0, 3'd3, 3'd3, 0, 0, t, n, w1, w2, a1, bz);
    checks++; if ({acerto, afundou, tipo_afundado} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL seguinte_flags got %b exp 11010", {acerto, afundou, tipo_afundado}); end
    checks++; if (mem_p1[5] !== 64'd2 || w1 !== 1) begin
      errors++; $display("FAIL seguinte_mem got %h w %0d exp 2 1", mem_p1[5], w1); end
  endtask

  // Reset asserted during cycle N+5, before the scan reaches the target at addr 8.
  task automatic test_reset_meio();
    int b1, b2, nr;
    mem_load(1'b0, 5'd8, 64'd7 | (64'hAD << 3));
    @(negedge clk);
    b1 = n_we1; b2 = n_we2; nr = 0;
    jogador = 1'b0; linha = 3'd5; coluna = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) begin
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, ready, we_P1, we_P2} !== 4'b0) begin
          errors++; $display("FAIL rstmeio_ctrl got %b exp 0000", {busy, ready, we_P1, we_P2}); end
        checks++; if (addr !== 5'd0 || wr_data !== 64'h0) begin
          errors++; $display("FAIL rstmeio_porta got addr %0d data %h exp 0 0", addr, wr_data); end
      end
      if (k == 6) rst_n = 1'b1;
      if (k >= 6 && ready) nr++;
    end
    checks++; if (nr !== 0) begin errors++; $display("FAIL rstmeio_ready got %0d exp 0", nr); end
    checks++; if (n_we1 - b1 !== 0 || n_we2 - b2 !== 0) begin
      errors++; $display("FAIL rstmeio_escritas got %0d/%0d exp 0/0", n_we1 - b1, n_we2 - b2); end
    checks++; if (mem_p1[8] !== (64'd7 | (64'hAD << 3))) begin
      errors++; $display("FAIL rstmeio_mem got %h", mem_p1[8]); end
  endtask

`ifdef CONTADOR_ACERTOS_EN
  // 32 distinct P1 coordinates (rows 0..3, cols 0..7) spread over entries 0..6.
  task automatic test_contador();
    int t, n, w1, w2; logic [4:0] a1; logic bz;
    logic [63:0] palavras [0:6];
    logic [7:0]  sl;
    mem_clear();
    for (int e = 0; e < 7; e++) palavras[e] = 64'd1;
    for (int i = 0; i < 32; i++) begin
      sl = 8'h80 | 8'((i / 8) << 3) | 8'(i % 8);
      palavras[i / 5] = palavras[i / 5] | (64'(sl) << (3 + 8 * (i % 5)));
    end
    for (int e = 0; e < 7; e++) mem_load(1'b0, 5'(e), palavras[e]);
    for (int i = 0; i < 32; i++) begin
      run_shot(1'b0, 3'(i / 8), 3'(i % 8), 0, 0, t, n, w1, w2, a1, bz);
      if (i == 0) begin
        checks++; if (acertos_P1 !== 5'd1) begin errors++; $display("FAIL contador_um got %0d exp 1", acertos_P1); end
      end
      if (i == 30) begin
        checks++; if (acertos_P1 !== 5'd31) begin errors++; $display("FAIL contador_31 got %0d exp 31", acertos_P1); end
      end
    end
    checks++; if (acertos_P1 !== 5'd31) begin errors++; $display("FAIL contador_satura got %0d exp 31", acertos_P1); end
    checks++; if (acertos_P2 !== 5'd0) begin errors++; $display("FAIL contador_P2 got %0d exp 0", acertos_P2); end
  endtask
`endif

  initial begin
    test_reset();
    test_afunda();
    test_parcial();
    test_repete();
    test_multiplo();
    test_start_ignorado();
    test_reset_meio();
`ifdef CONTADOR_ACERTOS_EN
    test_contador();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
